id_hazard_scoreboard: RTL and testbench



---
 rtl/id_hazard_scoreboard_pkg.sv | 17 +
 rtl/id_hazard_scoreboard_if.sv | 35 +++
 rtl/id_hazard_scoreboard_match.sv | 32 +++
 rtl/id_hazard_scoreboard.sv | 137 +++++++++++++
 tb/tb_id_hazard_scoreboard.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
// The entry struct is sized by AW_DEF; instantiate the scoreboard with AW = AW_DEF.
package hazard_pkg;

  localparam int AW_DEF = 5;
  localparam int RDY_W  = 4;
  localparam int FWD_RF = 0;
  localparam logic [AW_DEF-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic [AW_DEF-1:0] wn;
    logic [RDY_W-1:0]  rdy_cnt;
  } entry_t;

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// ID-stage request / hazard-response bundle between the decoder and the scoreboard.
// master = decode stage driving the instruction, slave = scoreboard answering.
interface id_hazard_scoreboard_if import hazard_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int SW = 2
);

  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_rs_used;
  logic          id_rt_used;
  logic          id_wreg;
  logic [AW-1:0] id_wn;
  logic          id_is_load;
  logic          id_is_mul;
  logic          flush;
  logic          stall;
  logic [SW-1:0] fwd_a;
  logic [SW-1:0] fwd_b;
  logic          mul_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wreg, id_wn,
           id_is_load, id_is_mul, flush,
    input  stall, fwd_a, fwd_b, mul_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wreg, id_wn,
           id_is_load, id_is_mul, flush,
    output stall, fwd_a, fwd_b, mul_busy
  );

endinterface

// File: rtl/id_hazard_scoreboard_match.sv
// One source operand compared against every in-flight entry.
// Reports whether any entry hits, the youngest (lowest) hitting index and
// whether that entry's data is already forwardable.
module hazard_match import hazard_pkg::*; #(
  parameter int DEPTH = 3,
  parameter int AW    = AW_DEF,
  parameter int SW    = $clog2(DEPTH+1)
) (
  input  entry_t        entries [DEPTH],
  input  logic [AW-1:0] r,
  input  logic          used,
  output logic          hit,
  output logic [SW-1:0] idx,
  output logic          ready
);

  // Scan oldest to youngest so the youngest match is the one left standing
  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    ready = 1'b0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (entries[k].valid && entries[k].wreg && entries[k].wn == r &&
          r != '0 && used) begin
        hit   = 1'b1;
        idx   = SW'(k);
        ready = (entries[k].rdy_cnt == '0);
      end
    end
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard / forwarding scoreboard for the pipelined MIPS core.
// Tracks DEPTH post-ID stages, load latency and a multi-cycle multiplier.
// Build option: ID_HAZARD_FWD_EN enables forwarding; without it every
// dependency stalls until the producer leaves the tracked window.
// The bus interface must be instantiated with the same AW and SW.
module id_hazard_scoreboard import hazard_pkg::*; #(
  parameter int AW       = AW_DEF,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 4,
  parameter int SW       = $clog2(DEPTH+1)
) (
  input logic                  clk,
  input logic                  clrn,
  id_hazard_scoreboard_if.slave bus
);

  localparam int MW = $clog2(MUL_LAT);
  localparam logic [MW-1:0] MUL_INIT = MW'(MUL_LAT-1);

  entry_t        ent   [DEPTH];
  entry_t        aged  [DEPTH];
  entry_t        new_ent;
  logic [MW-1:0] mul_cnt;
  logic [AW-1:0] mul_wn;
  logic          mul_busy;
  logic          stall;
  logic          accept;
  logic          hit_a, hit_b, ready_a, ready_b;
  logic [SW-1:0] idx_a, idx_b;
  logic          hz_a, hz_b, mul_hz;
  logic [SW-1:0] fwd_a, fwd_b;

  hazard_match #(.DEPTH(DEPTH), .AW(AW), .SW(SW)) u_match_rs (
    .entries (ent),
    .r       (bus.id_rs),
    .used    (bus.id_rs_used),
    .hit     (hit_a),
    .idx     (idx_a),
    .ready   (ready_a)
  );

  hazard_match #(.DEPTH(DEPTH), .AW(AW), .SW(SW)) u_match_rt (
    .entries (ent),
    .r       (bus.id_rt),
    .used    (bus.id_rt_used),
    .hit     (hit_b),
    .idx     (idx_b),
    .ready   (ready_b)
  );

  assign accept   = bus.id_valid & ~stall & ~bus.flush;
  assign mul_busy = (mul_cnt != '0);

  // Build the entry that enters EXE this cycle (bubble unless ID issues)
  always_comb begin
    new_ent = '0;
    if (accept) begin
      new_ent.valid = 1'b1;
      new_ent.wreg  = bus.id_wreg;
      new_ent.wn    = bus.id_wn;
`ifdef ID_HAZARD_FWD_EN
      new_ent.rdy_cnt = bus.id_is_load ? RDY_W'(LOAD_LAT) : '0;
`endif
    end
  end

  // Age each entry by one stage, counting load latency down to zero
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      aged[k] = ent[k];
`ifdef ID_HAZARD_FWD_EN
      if (ent[k].rdy_cnt != '0) aged[k].rdy_cnt = ent[k].rdy_cnt - 1'b1;
`endif
    end
  end

  // Shift the in-flight window; the oldest entry falls off the end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
    end else begin
      ent[0] <= new_ent;
      for (int k = 1; k < DEPTH; k++) ent[k] <= aged[k-1];
    end
  end

  // Multiplier occupancy counter and its destination register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mul_cnt <= '0;
      mul_wn  <= '0;
    end else if (accept && bus.id_is_mul) begin
      mul_cnt <= MUL_INIT;
      mul_wn  <= bus.id_wn;
    end else if (mul_cnt != '0) begin
      mul_cnt <= mul_cnt - 1'b1;
    end
  end

`ifdef ID_HAZARD_FWD_EN
  // Forward from the youngest producer when its data is ready, else stall
  always_comb begin
    hz_a  = hit_a & ~ready_a;
    hz_b  = hit_b & ~ready_b;
    fwd_a = (hit_a && ready_a) ? idx_a + SW'(1) : SW'(FWD_RF);
    fwd_b = (hit_b && ready_b) ? idx_b + SW'(1) : SW'(FWD_RF);
  end
`else
  logic unused_match;
  assign unused_match = ^{ready_a, ready_b, idx_a, idx_b};

  // No bypass network: any pending producer stalls the consumer
  always_comb begin
    hz_a  = hit_a;
    hz_b  = hit_b;
    fwd_a = SW'(FWD_RF);
    fwd_b = SW'(FWD_RF);
  end
`endif

  // Combine load-use, dependency and multiplier hazards into one stall
  always_comb begin
    mul_hz = mul_busy &
             (bus.id_is_mul |
              ((mul_wn != REG_ZERO) &
               ((bus.id_rs_used & (bus.id_rs == mul_wn)) |
                (bus.id_rt_used & (bus.id_rt == mul_wn)))));
    stall  = bus.id_valid & ~bus.flush & (hz_a | hz_b | mul_hz);
  end

  assign bus.stall    = stall;
  assign bus.fwd_a    = fwd_a;
  assign bus.fwd_b    = fwd_b;
  assign bus.mul_busy = mul_busy;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard (AW=5, DEPTH=3, LOAD_LAT=1, MUL_LAT=4).
// Expected stall counts and forwarding selects follow the ID_HAZARD_FWD_EN build.
module tb_id_hazard_scoreboard;

  localparam int AW = 5;
  localparam int SW = 2;
`ifdef ID_HAZARD_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic clk;
  logic clrn;
  int   checks;
  int   fails;
  int   n_stall;
  int   n_busy;

  id_hazard_scoreboard_if #(.AW(AW), .SW(SW)) bus ();

  id_hazard_scoreboard #(
    .AW(AW), .DEPTH(3), .LOAD_LAT(1), .MUL_LAT(4), .SW(SW)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [AW-1:0] rs, input logic ru,
                               input logic [AW-1:0] rt, input logic tu,
                               input logic wr, input logic [AW-1:0] wn,
                               input logic ld, input logic ml, input logic fl);
    bus.id_valid   = v;
    bus.id_rs      = rs;
    bus.id_rs_used = ru;
    bus.id_rt      = rt;
    bus.id_rt_used = tu;
    bus.id_wreg    = wr;
    bus.id_wn      = wn;
    bus.id_is_load = ld;
    bus.id_is_mul  = ml;
    bus.flush      = fl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (4) step();
  endtask

  // Hold the current instruction until stall drops; ends on the negedge where it is clear
  task automatic countStall(output int n, output int busy_n);
    n      = 0;
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mul_busy) busy_n++;
      if (!bus.stall) break;
      n++;
      step();
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    clrn   = 1'b0;
    idle();

    // Reset state
    @(negedge clk);
    checkOutput("reset_stall", bus.stall, 0);
    checkOutput("reset_fwd_a", bus.fwd_a, 0);
    checkOutput("reset_fwd_b", bus.fwd_b, 0);
    checkOutput("reset_mul_busy", bus.mul_busy, 0);
    step();
    clrn = 1'b1;
    step();

    // Back-to-back ALU: add $3 ; sub rs=$3
    applyStimulus(1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0, 0);
    @(negedge clk);
    checkOutput("b2b_producer_stall", bus.stall, 0);
    step();
    applyStimulus(1, 5'd3, 1, 5'd4, 1, 1, 5'd6, 0, 0, 0);
    countStall(n_stall, n_busy);
    checkOutput("b2b_stall_cycles", n_stall, FWD ? 0 : 3);
    checkOutput("b2b_fwd_a", bus.fwd_a, FWD ? 1 : 0);
    checkOutput("b2b_fwd_b", bus.fwd_b, 0);
    step();
    drain();

    // One instruction apart: add $3 ; nop ; sub rs=$3
    applyStimulus(1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0, 0);
    step();
    idle();
    step();
    applyStimulus(1, 5'd3, 1, 5'd4, 1, 1, 5'd6, 0, 0, 0);
    countStall(n_stall, n_busy);
    checkOutput("gap1_stall_cycles", n_stall, FWD ? 0 : 2);
    checkOutput("gap1_fwd_a", bus.fwd_a, FWD ? 2 : 0);
    step();
    drain();

    // Destination $0 never creates a dependency
    applyStimulus(1, 5'd1, 1, 5'd2, 1, 1, 5'd0, 0, 0, 0);
    step();
    applyStimulus(1, 5'd0, 1, 5'd4, 1, 1, 5'd6, 0, 0, 0);
    @(negedge clk);
    checkOutput("zero_stall", bus.stall, 0);
    checkOutput("zero_fwd_a", bus.fwd_a, 0);
    step();
    drain();

    // Load-use: lw $5 ; add rt=$5
    applyStimulus(1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 1, 0, 0);
    step();
    applyStimulus(1, 5'd1, 1, 5'd5, 1, 1, 5'd8, 0, 0, 0);
    countStall(n_stall, n_busy);
    checkOutput("load_use_stall_cycles", n_stall, FWD ? 1 : 3);
    checkOutput("load_use_fwd_b", bus.fwd_b, FWD ? 2 : 0);
    checkOutput("load_use_fwd_a", bus.fwd_a, 0);
    step();
    drain();

    // Flush wins over a load-use hazard and leaves a bubble behind
    applyStimulus(1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 1, 0, 0);
    step();
    applyStimulus(1, 5'd1, 1, 5'd5, 1, 1, 5'd9, 0, 0, 1);
    @(negedge clk);
    checkOutput("flush_stall", bus.stall, 0);
    step();
    applyStimulus(1, 5'd9, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    @(negedge clk);
    checkOutput("flush_bubble_stall", bus.stall, 0);
    checkOutput("flush_bubble_fwd_a", bus.fwd_a, 0);
    step();
    drain();

    // Multiply then dependent add
    applyStimulus(1, 5'd1, 1, 5'd2, 1, 1, 5'd7, 0, 1, 0);
    @(negedge clk);
    checkOutput("mul_issue_busy", bus.mul_busy, 0);
    checkOutput("mul_issue_stall", bus.stall, 0);
    step();
    applyStimulus(1, 5'd7, 1, 5'd0, 0, 1, 5'd8, 0, 0, 0);
    countStall(n_stall, n_busy);
    checkOutput("mul_dep_stall_cycles", n_stall, 3);
    checkOutput("mul_busy_cycles", n_busy, 3);
    checkOutput("mul_dep_fwd_a", bus.fwd_a, 0);
    step();
    drain();

    // Multiply, independent add, then a second multiply
    applyStimulus(1, 5'd1, 1, 5'd2, 1, 1, 5'd7, 0, 1, 0);
    step();
    applyStimulus(1, 5'd8, 1, 5'd9, 1, 1, 5'd10, 0, 0, 0);
    @(negedge clk);
    checkOutput("mul_indep_stall", bus.stall, 0);
    checkOutput("mul_indep_busy", bus.mul_busy, 1);
    step();
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 1, 5'd11, 0, 1, 0);
    countStall(n_stall, n_busy);
    checkOutput("mul2_stall_cycles", n_stall, 2);
    step();
    idle();
    @(negedge clk);
    checkOutput("mul2_issued_busy", bus.mul_busy, 1);
    step();
    drain();

    // Asynchronous reset in the middle of a multiply hazard
    applyStimulus(1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0, 0);
    step();
    applyStimulus(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0, 1, 0);
    step();
    applyStimulus(1, 5'd7, 1, 5'd0, 0, 1, 5'd12, 0, 0, 0);
    @(negedge clk);
    checkOutput("pre_reset_stall", bus.stall, 1);
    checkOutput("pre_reset_busy", bus.mul_busy, 1);
    #2;
    clrn = 1'b0;
    #1;
    checkOutput("async_reset_stall", bus.stall, 0);
    checkOutput("async_reset_busy", bus.mul_busy, 0);
    checkOutput("async_reset_fwd_a", bus.fwd_a, 0);
    step();
    clrn = 1'b1;
    applyStimulus(1, 5'd3, 1, 5'd0, 0, 1, 5'd13, 0, 0, 0);
    @(negedge clk);
    checkOutput("post_reset_fwd_a", bus.fwd_a, 0);
    checkOutput("post_reset_stall", bus.stall, 0);
    step();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
